// File: rtl/servo_pwm_capture.sv
// Servo PWM pulse-width decoder: measures the high time of pwm_in and maps 1..2 ms onto an
// 8-bit angle using a bit-serial restoring divider, with glitch, stuck-high and loss detection.
module servo_pwm_capture #(
  parameter int unsigned freq = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       clamped,
  output logic       signal_lost
);

  localparam logic [31:0] C1  = 32'(freq / 1_000);
  localparam logic [31:0] C05 = C1 / 2;
  localparam logic [31:0] C2  = 2 * C1;
  localparam logic [31:0] C3  = 3 * C1;
  localparam logic [31:0] C25 = 25 * C1;
  localparam logic [3:0]  LAST_STEP = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_CALC} state_t;

  state_t      r_state, w_next;
  logic        r_s1, r_s2, r_s3;
  logic [1:0]  r_fill;
  logic        r_armed;
  logic [31:0] r_width, r_wclamp, r_loss_cnt;
  logic        r_clamp_next;
  logic [3:0]  r_step;
  logic [39:0] r_rem, r_div;
  logic [7:0]  r_quo;

  logic        w_rise, w_fall, w_glitch, w_stuck, w_clip;
  logic [31:0] w_wc;
  logic [39:0] w_d, w_n, w_trial;

  // A high line seen straight out of reset is not a genuine edge: arm only after a real low sample.
  assign w_rise   = r_armed & r_s2 & ~r_s3;
  assign w_fall   = ~r_s2 & r_s3;
  assign w_glitch = r_width < C05;
  assign w_stuck  = r_width >= C3;
  assign w_clip   = (r_width < C1) || (r_width > C2);
  assign w_wc     = (r_width < C1) ? C1 : ((r_width > C2) ? C2 : r_width);
  assign w_d      = {8'd0, r_wclamp - C1};
  assign w_n      = (w_d << 8) - w_d;
  assign w_trial  = r_rem - r_div;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_rise) w_next = ST_HIGH;
      ST_HIGH: begin
        if (w_fall)       w_next = w_glitch ? ST_IDLE : ST_CALC;
        else if (w_stuck) w_next = ST_IDLE;
      end
      ST_CALC: if (r_step == LAST_STEP) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0; r_s2 <= 1'b0; r_s3 <= 1'b0;
      r_fill <= 2'b00; r_armed <= 1'b0;
      r_width <= '0; r_wclamp <= '0; r_loss_cnt <= '0;
      r_clamp_next <= 1'b0; r_step <= '0;
      r_rem <= '0; r_div <= '0; r_quo <= '0;
      angle <= '0; angle_valid <= 1'b0; clamped <= 1'b0; signal_lost <= 1'b1;
    end else begin
      r_s1    <= pwm_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & ~r_s2);
      angle_valid <= 1'b0;

      unique case (r_state)
        ST_IDLE: if (w_rise) r_width <= 32'd1;
        ST_HIGH: begin
          if (w_fall) begin
            if (!w_glitch) begin
              r_wclamp     <= w_wc;
              r_clamp_next <= w_clip;
              r_step       <= '0;
            end
          end else if (w_stuck) begin
            signal_lost <= 1'b1;
          end else begin
            r_width <= r_width + 32'd1;
          end
        end
        ST_CALC: begin
          r_step <= r_step + 4'd1;
          if (r_step == 4'd0) begin
            // Divisor pre-shifted so eight compare/subtract steps yield quotient bits 7..0.
            r_rem <= w_n;
            r_div <= {8'd0, C1} << 7;
            r_quo <= '0;
          end else if (r_step <= 4'd8) begin
            if (r_rem >= r_div) begin
              r_rem <= w_trial;
              r_quo <= {r_quo[6:0], 1'b1};
            end else begin
              r_quo <= {r_quo[6:0], 1'b0};
            end
            r_div <= r_div >> 1;
          end else begin
            angle       <= r_quo;
            clamped     <= r_clamp_next;
            angle_valid <= 1'b1;
            signal_lost <= 1'b0;
          end
        end
        default: ;
      endcase

      if (w_rise) begin
        r_loss_cnt <= '0;
      end else if (r_loss_cnt < C25) begin
        r_loss_cnt <= r_loss_cnt + 32'd1;
        if (r_loss_cnt == C25 - 32'd1) signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Randomised and directed bench for servo_pwm_capture at freq = 100_000 (1 ms = 100 cycles),
// checking decoded pulses against an arithmetic model of the width-to-angle mapping.
module tb_servo_pwm_capture;

  localparam int FREQ = 100_000;
  localparam int C1   = FREQ / 1_000;
  localparam int C05  = C1 / 2;
  localparam int LAT  = 13;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic [7:0] angle;
  logic       angle_valid;
  logic       clamped;
  logic       signal_lost;

  int n_vec = 0;
  int n_err = 0;
  int exp_angle, exp_clamped, exp_lost;

  servo_pwm_capture #(.freq(FREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .angle       (angle),
    .angle_valid (angle_valid),
    .clamped     (clamped),
    .signal_lost (signal_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_angle(input int w);
    int wc;
    wc = (w < C1) ? C1 : ((w > 2 * C1) ? 2 * C1 : w);
    return ((wc - C1) * 255) / C1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_angle"},   32'(angle),       0);
    check({tag, "_valid"},   32'(angle_valid), 0);
    check({tag, "_clamped"}, 32'(clamped),     0);
    check({tag, "_lost"},    32'(signal_lost), 1);
    exp_angle = 0; exp_clamped = 0; exp_lost = 1;
  endtask

  // Called #1 after a rising edge; hi samples high then lo samples low.
  task automatic run_pulse(input int hi, input int lo, output int n_strobe, output int strobe_at);
    n_strobe = 0;
    strobe_at = -1;
    pwm_in = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      @(posedge clk); #1;
      if (angle_valid) n_strobe++;
    end
    pwm_in = 1'b0;
    for (int i = 1; i <= lo; i++) begin
      @(posedge clk); #1;
      if (angle_valid) begin
        n_strobe++;
        strobe_at = i;
      end
    end
  endtask

  task automatic apply(input int hi, input int lo, input string tag);
    int ns, at;
    run_pulse(hi, lo, ns, at);
    if (hi < C05) begin
      check({tag, "_nstrobe"}, 32'(ns), 0);
    end else begin
      exp_angle   = ref_angle(hi);
      exp_clamped = (hi < C1 || hi > 2 * C1) ? 1 : 0;
      exp_lost    = 0;
      check({tag, "_nstrobe"}, 32'(ns), 1);
      check({tag, "_latency"}, 32'(at), LAT);
    end
    check({tag, "_angle"},   32'(angle),       32'(exp_angle));
    check({tag, "_clamped"}, 32'(clamped),     32'(exp_clamped));
    check({tag, "_lost"},    32'(signal_lost), 32'(exp_lost));
  endtask

  task automatic count_strobes(input int cycles, output int ns);
    ns = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (angle_valid) ns++;
    end
  endtask

  initial begin
    int ns;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    apply(150, 40, "w150");
    apply(100, 40, "w100");
    apply(200, 40, "w200");
    apply(90,  40, "w90");
    apply(230, 40, "w230");
    apply(40,  40, "glitch40");

    // Line stuck high for 400 samples: loss flagged near width 300, no measurement.
    ns = 0;
    pwm_in = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (angle_valid) ns++;
      if (i == 290) check("stuck_lost_early", 32'(signal_lost), 0);
      if (i == 310) check("stuck_lost_set",   32'(signal_lost), 1);
    end
    pwm_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (angle_valid) ns++;
    end
    check("stuck_nstrobe", 32'(ns), 0);
    check("stuck_angle",   32'(angle), 32'(exp_angle));
    exp_lost = 1;
    apply(150, 40, "after_stuck");

    // Idle line after a valid pulse: loss 2500 cycles after the rise, angle held.
    pwm_in = 1'b1;
    for (int t = 1; t <= 2600; t++) begin
      @(posedge clk); #1;
      if (t == 150) pwm_in = 1'b0;
      if (t == 2495) check("loss_early", 32'(signal_lost), 0);
      if (t == 2510) begin
        check("loss_set",        32'(signal_lost), 1);
        check("loss_angle_hold", 32'(angle), 32'(ref_angle(150)));
      end
    end
    exp_lost = 1;

    // Reset in the middle of a high pulse; line is still high on release.
    pwm_in = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_high");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    count_strobes(40, ns);
    check("rst_high_nstrobe", 32'(ns), 0);
    apply(170, 40, "post_rst_high");

    // Reset while the divider is running.
    pwm_in = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_calc");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_strobes(40, ns);
    check("rst_calc_nstrobe", 32'(ns), 0);
    apply(180, 40, "post_rst_calc");

    for (int k = 0; k < 25; k++) begin
      apply(int'($urandom_range(30, 260)), int'($urandom_range(25, 80)), $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
